// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word layout and the ID/EX next-state action.
package pipe_pkg;

  localparam int unsigned CTRL_W = 9;

  // Control word bit positions, MSB first in decode order.
  localparam int unsigned CTRL_REGWRITE = 8;
  localparam int unsigned CTRL_MEMTOREG = 7;
  localparam int unsigned CTRL_MEMREAD  = 6;
  localparam int unsigned CTRL_MEMWRITE = 5;
  localparam int unsigned CTRL_ALUSRC   = 4;
  localparam int unsigned CTRL_REGDST   = 3;
  localparam int unsigned CTRL_ALUOP_HI = 2;
  localparam int unsigned CTRL_ALUOP_LO = 1;
  localparam int unsigned CTRL_BRANCH   = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    ActHold   = 2'd0,
    ActBubble = 2'd1,
    ActLoad   = 2'd2
  } stage_act_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: decoded inputs from ID and the registered EX-side view.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic [pipe_pkg::CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0]           rs_data_i;
  logic [DATA_W-1:0]           rt_data_i;
  logic [DATA_W-1:0]           imm_i;
  logic [4:0]                  rs_addr_i;
  logic [4:0]                  rt_addr_i;
  logic [4:0]                  rd_addr_i;

  logic [pipe_pkg::CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0]           rs_data_o;
  logic [DATA_W-1:0]           rt_data_o;
  logic [DATA_W-1:0]           imm_o;
  logic [4:0]                  rs_addr_o;
  logic [4:0]                  rt_addr_o;
  logic [4:0]                  rd_addr_o;
  logic                        valid_o;
  logic                        stall_o;

  modport master (
    output ctrl_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
    input  ctrl_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
    input  valid_o, stall_o
  );

  modport slave (
    input  ctrl_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
    output ctrl_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
    output valid_o, stall_o
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read by the
// instruction in ID. rt is always compared, so a few false stalls are accepted.
module load_use_detect (
  input  logic       ex_mem_read_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rt_addr_i,
  input  logic [4:0] id_rs_addr_i,
  input  logic [4:0] id_rt_addr_i,
  output logic       haz_o
);

  always_comb begin
    haz_o = ex_mem_read_i && ex_valid_i && (ex_rt_addr_i != 5'd0) &&
            ((ex_rt_addr_i == id_rs_addr_i) || (ex_rt_addr_i == id_rt_addr_i));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation and a saturating bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic               cnt_clr_i,
  id_ex_stage_if.slave       bus,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [4:0]        rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              haz;
  stage_act_e        act;

  load_use_detect u_detect (
    .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
    .ex_valid_i    (valid_q),
    .ex_rt_addr_i  (rt_addr_q),
    .id_rs_addr_i  (bus.rs_addr_i),
    .id_rt_addr_i  (bus.rt_addr_i),
    .haz_o         (haz)
  );

  always_comb begin
    if (hold_i)                act = ActHold;
    else if (flush_i || haz)   act = ActBubble;
    else                       act = ActLoad;
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    valid_d   = valid_q;
    unique case (act)
      ActHold: ;
      // Zeroed addresses keep the forwarding unit from matching against a bubble.
      ActBubble: begin
        ctrl_d    = BUBBLE_CTRL;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_addr_d = '0;
        rt_addr_d = '0;
        rd_addr_d = '0;
        valid_d   = 1'b0;
      end
      ActLoad: begin
        ctrl_d    = bus.ctrl_i;
        rs_data_d = bus.rs_data_i;
        rt_data_d = bus.rt_data_i;
        imm_d     = bus.imm_i;
        rs_addr_d = bus.rs_addr_i;
        rt_addr_d = bus.rt_addr_i;
        rd_addr_d = bus.rd_addr_i;
        valid_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Only hazard bubbles count; a clear in the same cycle wins over the increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (cnt_clr_i)                          cnt_d = '0;
      else if (haz && !flush_i && !(&cnt_q))  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= BUBBLE_CTRL;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ctrl_o    = ctrl_q;
  assign bus.rs_data_o = rs_data_q;
  assign bus.rt_data_o = rt_data_q;
  assign bus.imm_o     = imm_q;
  assign bus.rs_addr_o = rs_addr_q;
  assign bus.rt_addr_o = rt_addr_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.valid_o   = valid_q;
  assign bus.stall_o   = haz && !flush_i;
  assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hold/reset/saturation sequences and
// randomized traffic checked against an instruction-level model of the EX slot.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam logic [8:0] LW_C  = 9'h1D0;  // RegWrite MemtoReg MemRead ALUSrc
  localparam logic [8:0] ADD_C = 9'h10C;  // RegWrite RegDst ALUOp=10

  logic          clk = 1'b0;
  logic          rst, hold, flush, clr;
  logic [CW-1:0] cnt;

  id_ex_stage_if #(.DATA_W(DW)) bus ();

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .hold_i       (hold),
    .flush_i      (flush),
    .cnt_clr_i    (clr),
    .bus          (bus),
    .bubble_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
  } ex_t;

  ex_t  m_ex;
  int   m_cnt;
  bit   use_model;
  logic s_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // EX slot holds a load whose destination the ID instruction names.
  function automatic bit m_load_use();
    return m_ex.valid && m_ex.ctrl[CTRL_MEMREAD] && m_ex.rt != 5'd0 &&
           (m_ex.rt == bus.rs_addr_i || m_ex.rt == bus.rt_addr_i);
  endfunction

  function automatic ex_t dut_ex();
    return '{bus.valid_o, bus.ctrl_o, bus.rs_data_o, bus.rt_data_o, bus.imm_o,
             bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o};
  endfunction

  task automatic drive(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd);
    bus.ctrl_i    = c;
    bus.rs_addr_i = rs;
    bus.rt_addr_i = rt;
    bus.rd_addr_i = rd;
    bus.rs_data_i = rsd;
    bus.rt_data_i = rsd ^ 32'h5A5A_0000;
    bus.imm_i     = {27'd0, rd} + 32'h100;
  endtask

  // Called at a negedge with inputs settled; returns at the following negedge.
  task automatic step();
    bit lu;
    #1;
    s_stall = bus.stall_o;
    lu = m_load_use();
    if (use_model) chk("model_stall", 64'(s_stall), 64'(lu && !flush));
    @(posedge clk);
    if (!hold) begin
      if (clr) m_cnt = 0;
      else if (lu && !flush && m_cnt < CNT_MAX) m_cnt++;
      if (flush || lu) m_ex = '0;
      else m_ex = '{1'b1, bus.ctrl_i, bus.rs_data_i, bus.rt_data_i, bus.imm_i,
                    bus.rs_addr_i, bus.rt_addr_i, bus.rd_addr_i};
    end
    #1;
    if (use_model) begin
      n_tests++;
      if (dut_ex() !== m_ex || int'(cnt) != m_cnt) begin
        n_fail++;
        $display("FAIL model_state: got %h cnt %0d expected %h cnt %0d",
                 dut_ex(), cnt, m_ex, m_cnt);
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic       flush;
    logic [8:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic       e_stall, e_valid;
    logic [8:0] e_ctrl;
    logic [4:0] e_rs;
    int         e_cnt;
  } vec_t;

  vec_t vecs[8];
  int   saved_cnt;

  initial begin
    // lw $2,0($1); add $3,$2,$4 (one stall); lw $0; add $3,$0,$4; lw $5 + flushed consumer.
    vecs[0] = '{1'b0, LW_C,  5'd1, 5'd2, 5'd0, 1'b0, 1'b1, LW_C,  5'd1, 0};
    vecs[1] = '{1'b0, ADD_C, 5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 9'd0,  5'd0, 1};
    vecs[2] = '{1'b0, ADD_C, 5'd2, 5'd4, 5'd3, 1'b0, 1'b1, ADD_C, 5'd2, 1};
    vecs[3] = '{1'b0, LW_C,  5'd1, 5'd0, 5'd0, 1'b0, 1'b1, LW_C,  5'd1, 1};
    vecs[4] = '{1'b0, ADD_C, 5'd0, 5'd4, 5'd3, 1'b0, 1'b1, ADD_C, 5'd0, 1};
    vecs[5] = '{1'b0, LW_C,  5'd1, 5'd5, 5'd0, 1'b0, 1'b1, LW_C,  5'd1, 1};
    vecs[6] = '{1'b1, ADD_C, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 9'd0,  5'd0, 1};
    vecs[7] = '{1'b0, ADD_C, 5'd5, 5'd5, 5'd6, 1'b0, 1'b1, ADD_C, 5'd5, 1};

    rst = 1'b1; hold = 1'b0; flush = 1'b0; clr = 1'b0; use_model = 1'b0;
    m_ex = '0; m_cnt = 0;
    drive(9'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(bus.valid_o), 64'd0);
    chk("reset_ctrl", 64'(bus.ctrl_o), 64'd0);
    chk("reset_cnt", 64'(cnt), 64'd0);
    chk("reset_stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      flush = vecs[i].flush;
      drive(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, 32'h1000 + 32'(i));
      step();
      chk($sformatf("vec%0d_stall", i), 64'(s_stall), 64'(vecs[i].e_stall));
      chk($sformatf("vec%0d_valid", i), 64'(bus.valid_o), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_ctrl", i), 64'(bus.ctrl_o), 64'(vecs[i].e_ctrl));
      chk($sformatf("vec%0d_rs_addr", i), 64'(bus.rs_addr_o), 64'(vecs[i].e_rs));
      chk($sformatf("vec%0d_cnt", i), 64'(cnt), 64'(vecs[i].e_cnt));
    end
    flush = 1'b0;

    // Hold for three cycles with a hazard pending and changing operand data.
    use_model = 1'b1;
    drive(LW_C, 5'd1, 5'd7, 5'd0, 32'hAAAA);
    step();
    saved_cnt = int'(cnt);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(ADD_C, 5'd7, 5'd4, 5'd3, $urandom);
      step();
      chk("hold_stall", 64'(s_stall), 64'd1);
      chk("hold_rs_data", 64'(bus.rs_data_o), 64'h0000_AAAA);
      chk("hold_ctrl", 64'(bus.ctrl_o), 64'(LW_C));
      chk("hold_cnt", 64'(cnt), 64'(saved_cnt));
    end
    hold = 1'b0;
    step();
    chk("release_bubble_valid", 64'(bus.valid_o), 64'd0);
    chk("release_cnt", 64'(cnt), 64'(saved_cnt + 1));
    bus.rs_data_i = 32'hBEEF_0001;
    step();
    chk("release_capture", 64'(bus.rs_data_o), 64'hBEEF_0001);
    chk("release_valid", 64'(bus.valid_o), 64'd1);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("areset_valid", 64'(bus.valid_o), 64'd0);
    chk("areset_ctrl", 64'(bus.ctrl_o), 64'd0);
    chk("areset_rs_data", 64'(bus.rs_data_o), 64'd0);
    chk("areset_rs_addr", 64'(bus.rs_addr_o), 64'd0);
    chk("areset_cnt", 64'(cnt), 64'd0);
    #1 rst = 1'b0;
    m_ex = '0; m_cnt = 0;
    @(negedge clk);
    drive(ADD_C, 5'd3, 5'd4, 5'd5, 32'h77);
    step();
    chk("post_reset_valid", 64'(bus.valid_o), 64'd1);

    // Seventeen hazards saturate the 4-bit counter; clear beats a simultaneous hazard.
    for (int k = 0; k < 17; k++) begin
      drive(LW_C, 5'd1, 5'd2, 5'd0, 32'(k));
      step();
      drive(ADD_C, 5'd2, 5'd4, 5'd3, 32'(k));
      step();
      chk("sat_cnt", 64'(cnt), 64'((k + 1 < CNT_MAX) ? k + 1 : CNT_MAX));
    end
    drive(LW_C, 5'd1, 5'd2, 5'd0, 32'd0);
    step();
    clr = 1'b1;
    drive(ADD_C, 5'd4, 5'd2, 5'd3, 32'd0);
    step();
    clr = 1'b0;
    chk("clr_stall", 64'(s_stall), 64'd1);
    chk("clr_cnt", 64'(cnt), 64'd0);

    // Randomized traffic with small register numbers to provoke frequent matches.
    for (int k = 0; k < 400; k++) begin
      logic [8:0] c;
      c = 9'($urandom);
      c[CTRL_MEMREAD] = $urandom_range(0, 1);
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      clr   = ($urandom_range(0, 29) == 0);
      drive(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS core: registers decoded control, operand data and register addresses from ID into EX, and contains the load-use hazard detector. It feeds the forwarding unit, the EX operand muxes and the ALU directly. On a load-use hazard it holds PC and IF/ID through `stall_o` and inserts one bubble into EX.

## Interface
Parameters:
- `DATA_W`, 32, operand and immediate width.
- `CNT_W`, 16, bubble counter width.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `hold_i`  in  1  external freeze from the memory stall; the stage keeps its contents.
- `flush_i`  in  1  kill the instruction now in ID; a bubble enters EX.
- `ctrl_i`  in  9  control bits from decode: RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0], Branch.
- `rs_data_i`, `rt_data_i`  in  DATA_W  register file read data.
- `imm_i`  in  DATA_W  sign-extended immediate.
- `rs_addr_i`, `rt_addr_i`, `rd_addr_i`  in  5  IF/ID instruction fields.
- `cnt_clr_i`  in  1  synchronous clear of the bubble counter.
- `ctrl_o`  out  9  registered control bits.
- `rs_data_o`, `rt_data_o`, `imm_o`  out  DATA_W  registered operands.
- `rs_addr_o`, `rt_addr_o`, `rd_addr_o`  out  5  registered addresses; these drive the forwarding unit.
- `valid_o`  out  1  1 when EX holds a real instruction, 0 when it holds a bubble.
- `stall_o`  out  1  combinational; 1 freezes PC and IF/ID.
- `bubble_cnt_o`  out  CNT_W  saturating count of inserted bubbles.

## Operation
- **Hazard.** `haz = ctrl_o.MemRead && valid_o && rt_addr_o != 0 && (rt_addr_o == rs_addr_i || rt_addr_o == rt_addr_i)`.
- **Stall output.** `stall_o = haz && !flush_i`.
- **Next-state priority**, highest first:
  - `rst_i`: every output register is 0. `valid_o`=0, `bubble_cnt_o`=0.
  - `hold_i`: all registers retain their values, including the counter.
  - `flush_i`: bubble.
  - `haz`: bubble; the counter increments.
  - Otherwise: capture all inputs; `valid_o`=1.
- **Bubble.** `ctrl_o`=0 and `valid_o`=0. Data and address registers also load 0, so the forwarding unit sees RegWrite=0 and address 0.
- **Counter.**
  - Increments only on hazard bubbles, not on flushes.
  - Saturates at all-ones.
  - `cnt_clr_i` clears it. `rst_i` and `hold_i` outrank `cnt_clr_i`.
  - A clear and an increment in the same cycle: the clear wins, giving 0.
- **Address 0 rule.** A load whose destination is $0 never stalls.
- **rt comparison.** rt is compared even when the consumer does not read rt. The resulting false stall is accepted.

## Timing
- Data path latency: 1 cycle, input to registered output.
- `stall_o` is combinational from the registered outputs and the current inputs.
- There is no path from `stall_o` back into the hazard term, so no combinational loop exists.
- A load-use pair costs exactly one stall cycle:
  - Cycle N: `lw` in EX, consumer in ID, `stall_o`=1.
  - Cycle N+1: bubble in EX, `stall_o`=0.
  - Edge ending N+1: the consumer is captured. Forwarding then supplies the load data from WB.
- `rst_i` asserted mid-operation clears the outputs immediately, without waiting for a clock edge. After deassertion, the first edge captures normally.
- With `hold_i`=1 and a hazard present, `stall_o` still reads 1. Upstream already treats the hold and the stall identically.

## Structure
- **Shared package `pipe_pkg`:**
  - Control bit-index constants: `CTRL_REGWRITE` … `CTRL_BRANCH`.
  - `CTRL_W`=9.
  - `BUBBLE_CTRL`=0.
- **Sub-module `load_use_detect`:** purely combinational hazard comparator producing `haz`. It is reused by the later branch-in-ID hazard work.
- **Top level:** holds the priority mux, the registers and the counter.

## Test plan
- **Load-use stall.** Sequence `lw $2,0($1)` then `add $3,$2,$4`. Required:
  - `stall_o`=1 for exactly one cycle.
  - Next cycle: `valid_o`=0 and `ctrl_o`=0.
  - The following cycle: `rs_addr_o`=2, `valid_o`=1.
  - `bubble_cnt_o`=1.
- **Destination $0.** `lw $0,0($1)` then `add $3,$0,$4`: `stall_o` stays 0 and no bubble is inserted.
- **Flush during hazard.** Load-use hazard with `flush_i`=1 in the same cycle. Required: `stall_o`=0, a bubble is inserted, `bubble_cnt_o` is unchanged.
- **Hold.** `hold_i`=1 for 3 cycles while `rs_data_i` changes each cycle. Required: `rs_data_o`, `ctrl_o` and `bubble_cnt_o` remain constant, then capture resumes on the first edge after release.
- **Asynchronous reset mid-stream.** `rst_i` pulsed between clock edges while `valid_o`=1. Required: all outputs read 0 before the next edge.
- **Counter saturation and clear.** Preload near the limit with CNT_W=4 and force 17 hazards. Required:
  - Count holds at 15.
  - `cnt_clr_i` together with a hazard gives 0.
